// File: rtl/fire_sequencer_module.sv
// Fire handshake initiator: sequences bursts of clear/mark/fire shots across the transducer channels.
// Define FIRE_SEQ_TIMEOUT_EN to compile in the per-shot completion timeout and the sticky timeoutErr flag.
module fire_sequencer_module #(
  parameter int NUM_CHANNELS = 8,
  parameter int ARM_CYCLES   = 4   // must be >= 2: channels latch delays one cycle after mark
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trig,
  input  logic                    abort,
  input  logic [15:0]             numShots,
  input  logic [31:0]             shotInterval,
  input  logic [31:0]             timeoutCycles,
  input  logic [NUM_CHANNELS-1:0] channelEnable,
  input  logic [NUM_CHANNELS-1:0] fireComplete,
  output logic [NUM_CHANNELS-1:0] isActive,
  output logic                    chanRst,
  output logic                    onYourMark,
  output logic                    GOGOGO_EXCLAMATION,
  output logic                    busy,
  output logic [15:0]             shotCount,
  output logic                    done,
  output logic                    timeoutErr
);

  typedef enum logic [2:0] {IDLE, CLEAR, MARK, FIRE, INTERVAL} stateT;

  stateT                   state, stateNext;
  logic                    abortPend, abortPendNext;
  logic [31:0]             cnt, cntNext;
  logic [NUM_CHANNELS-1:0] mask;
  logic [15:0]             shotsQ;
  logic [31:0]             intervalQ;

  logic [NUM_CHANNELS-1:0] isActiveNext;
  logic                    chanRstNext, markNext, goNext, busyNext, doneNext;
  logic [15:0]             shotCountNext;
  logic                    complete, timedOut, acceptTrig;

  // Disabled channels count as complete.
  assign complete   = &(fireComplete | ~mask);
  // An abort is still being wound down while abortPend is set, so trig is not yet accepted.
  assign acceptTrig = (state == IDLE) && !abortPend && trig;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    stateNext     = state;
    abortPendNext = 1'b0;
    cntNext       = cnt;
    isActiveNext  = isActive;
    chanRstNext   = 1'b0;
    markNext      = 1'b0;
    goNext        = 1'b0;
    busyNext      = busy;
    shotCountNext = shotCount;
    doneNext      = 1'b0;

    unique case (state)
      IDLE: begin
        if (abortPend) begin
          isActiveNext = '0;
          busyNext     = 1'b0;
          doneNext     = 1'b1;
        end else if (trig) begin
          shotCountNext = '0;
          if (numShots == 16'd0) begin
            doneNext = 1'b1;
          end else begin
            stateNext    = CLEAR;
            busyNext     = 1'b1;
            chanRstNext  = 1'b1;
            isActiveNext = channelEnable;
          end
        end
      end
      CLEAR: begin
        stateNext = MARK;
        markNext  = 1'b1;
        cntNext   = 32'(ARM_CYCLES - 1);
      end
      MARK: begin
        markNext = 1'b1;
        if (cnt == 32'd0) begin
          stateNext = FIRE;
          goNext    = 1'b1;
          cntNext   = '0;
        end else begin
          cntNext = cnt - 32'd1;
        end
      end
      FIRE: begin
        if (complete) begin
          shotCountNext = shotCount + 16'd1;
          if (shotCount + 16'd1 == shotsQ) begin
            stateNext    = IDLE;
            busyNext     = 1'b0;
            doneNext     = 1'b1;
            isActiveNext = '0;
          end else begin
            stateNext = INTERVAL;
            cntNext   = intervalQ;
          end
        end else if (timedOut) begin
          stateNext     = IDLE;
          abortPendNext = 1'b1;
          chanRstNext   = 1'b1;
        end else begin
          markNext = 1'b1;
          goNext   = 1'b1;
          cntNext  = cnt + 32'd1;   // cycles spent in FIRE, used by the timeout
        end
      end
      INTERVAL: begin
        if (cnt == 32'd0) begin
          stateNext   = CLEAR;
          chanRstNext = 1'b1;
        end else begin
          cntNext = cnt - 32'd1;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Abort beats a same-edge completion: the shot is not counted and the mask stays up for the clear.
    if (state != IDLE && abort) begin
      stateNext     = IDLE;
      abortPendNext = 1'b1;
      chanRstNext   = 1'b1;
      markNext      = 1'b0;
      goNext        = 1'b0;
      doneNext      = 1'b0;
      isActiveNext  = isActive;
      busyNext      = busy;
      shotCountNext = shotCount;
      cntNext       = cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the latched configuration is reset along with the control state so nothing powers up as X.
      state              <= IDLE;
      abortPend          <= 1'b0;
      cnt                <= '0;
      mask               <= '0;
      shotsQ             <= '0;
      intervalQ          <= '0;
      isActive           <= '0;
      chanRst            <= 1'b0;
      onYourMark         <= 1'b0;
      GOGOGO_EXCLAMATION <= 1'b0;
      busy               <= 1'b0;
      shotCount          <= '0;
      done               <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state              <= stateNext;
      abortPend          <= abortPendNext;
      cnt                <= cntNext;
      isActive           <= isActiveNext;
      chanRst            <= chanRstNext;
      onYourMark         <= markNext;
      GOGOGO_EXCLAMATION <= goNext;
      busy               <= busyNext;
      shotCount          <= shotCountNext;
      done               <= doneNext;
      if (acceptTrig) begin
        mask      <= channelEnable;
        shotsQ    <= numShots;
        intervalQ <= shotInterval;
      end
    end
  end

`ifdef FIRE_SEQ_TIMEOUT_EN
  logic [31:0] timeoutQ;
  logic        timeoutErrNext;

  // cnt is zero in the first FIRE cycle, so this fires after exactly timeoutQ FIRE cycles.
  assign timedOut = (timeoutQ != 32'd0) && (cnt == timeoutQ - 32'd1);

  always_comb begin
    timeoutErrNext = timeoutErr;
    if (acceptTrig)
      timeoutErrNext = 1'b0;
    else if (state == FIRE && !abort && !complete && timedOut)
      timeoutErrNext = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeoutQ   <= '0;
      timeoutErr <= 1'b0;
    end else begin
      timeoutErr <= timeoutErrNext;
      if (acceptTrig) timeoutQ <= timeoutCycles;
    end
  end
`else
  logic unusedTimeoutCycles;

  assign timedOut            = 1'b0;
  assign timeoutErr          = 1'b0;
  assign unusedTimeoutCycles = ^timeoutCycles;
`endif

endmodule

// File: tb/tb_fire_sequencer_module.sv
// Randomized bench for fire_sequencer_module: each burst's cycle-by-cycle outputs are predicted
// from the shot timeline (clear, mark, fire, interval, abort/timeout wind-down) built with plain arithmetic.
module tb_fire_sequencer_module;
  localparam int NCH = 8;
  localparam int ARM = 4;
`ifdef FIRE_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           trig = 1'b0;
  logic           abort = 1'b0;
  logic [15:0]    numShots = '0;
  logic [31:0]    shotInterval = '0;
  logic [31:0]    timeoutCycles = '0;
  logic [NCH-1:0] channelEnable = '0;
  logic [NCH-1:0] fireComplete = '0;
  logic [NCH-1:0] isActive;
  logic           chanRst, onYourMark, GOGOGO_EXCLAMATION, busy, done, timeoutErr;
  logic [15:0]    shotCount;

  fire_sequencer_module #(.NUM_CHANNELS(NCH), .ARM_CYCLES(ARM)) dut (
    .clk(clk), .rst(rst), .trig(trig), .abort(abort), .numShots(numShots),
    .shotInterval(shotInterval), .timeoutCycles(timeoutCycles),
    .channelEnable(channelEnable), .fireComplete(fireComplete),
    .isActive(isActive), .chanRst(chanRst), .onYourMark(onYourMark),
    .GOGOGO_EXCLAMATION(GOGOGO_EXCLAMATION), .busy(busy), .shotCount(shotCount),
    .done(done), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] act;
    logic           clr, mark, go, busy, dn, terr;
    logic [15:0]    cnt;
    logic           inFire, lastFire;
  } expT;

  expT         sched[$];
  int          tests = 0;
  int          fails = 0;
  int          burstId = 0;
  logic [15:0] lastCount = '0;
  logic        stickyErr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (burst %0d, t=%0t): got %0h, expected %0h", tag, burstId, $time, got, exp);
    end
  endtask

  task automatic checkOutputs(input expT e);
    check("isActive",   32'(isActive),           32'(e.act));
    check("chanRst",    32'(chanRst),            32'(e.clr));
    check("onYourMark", 32'(onYourMark),         32'(e.mark));
    check("fireStrobe", 32'(GOGOGO_EXCLAMATION), 32'(e.go));
    check("busy",       32'(busy),               32'(e.busy));
    check("shotCount",  32'(shotCount),          32'(e.cnt));
    check("done",       32'(done),               32'(e.dn));
    check("timeoutErr", 32'(timeoutErr),         32'(e.terr));
  endtask

  // Idle cycles with abort/fireComplete noise: nothing may move.
  task automatic idleCycles(input int n);
    expT e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.cnt  = lastCount;
      e.terr = stickyErr;
      checkOutputs(e);
      trig         = 1'b0;
      abort        = 1'($urandom_range(0, 1));
      fireComplete = NCH'($urandom);
      @(posedge clk); #1;
    end
    abort = 1'b0;
  endtask

  // Builds the expected timeline for one burst, then drives it and compares every cycle.
  task automatic runBurst(input int shots, input int gap, input int tmo, input logic [NCH-1:0] m,
                          input int abortAt, input int fireMin, input int fireMax);
    expT            e;
    int             fl, killAt;
    bit             killTmo;
    logic [NCH-1:0] lowBit;
    killAt  = -1;
    killTmo = 1'b0;
    lowBit  = m & (~m + 1'b1);
    burstId++;
    sched.delete();
    sched.push_back('0);
    if (shots == 0) begin
      e = '0;
      e.dn = 1'b1;
      sched.push_back(e);
    end
    for (int s = 0; s < shots && killAt < 0; s++) begin
      fl = (m == '0) ? 1 : int'($urandom_range(fireMax, fireMin));
      e = '0;
      e.act  = m;
      e.busy = 1'b1;
      e.cnt  = 16'(s);
      e.clr  = 1'b1;
      sched.push_back(e);
      e.clr  = 1'b0;
      e.mark = 1'b1;
      for (int k = 0; k < ARM; k++) sched.push_back(e);
      e.go     = 1'b1;
      e.inFire = 1'b1;
      for (int j = 1; j <= fl; j++) begin
        e.lastFire = (j == fl);
        if (TMO_EN && tmo != 0 && j == tmo && fl > tmo) begin
          e.lastFire = 1'b0;
          sched.push_back(e);
          killAt  = sched.size() - 1;
          killTmo = 1'b1;
          break;
        end
        sched.push_back(e);
      end
      if (killAt < 0) begin
        e = '0;
        e.cnt = 16'(s + 1);
        if (s == shots - 1) begin
          e.dn = 1'b1;
          sched.push_back(e);
        end else begin
          e.act  = m;
          e.busy = 1'b1;
          for (int k = 0; k <= gap; k++) sched.push_back(e);
        end
      end
    end
    if (killAt < 0 && abortAt > 0 && abortAt <= sched.size() - 2) killAt = abortAt;
    if (killAt >= 0) begin
      while (sched.size() > killAt + 1) void'(sched.pop_back());
      e = '0;
      e.act  = m;
      e.clr  = 1'b1;
      e.busy = 1'b1;
      e.cnt  = sched[killAt].cnt;
      e.terr = killTmo;
      sched.push_back(e);
      e.act  = '0;
      e.clr  = 1'b0;
      e.busy = 1'b0;
      e.dn   = 1'b1;
      sched.push_back(e);
    end

    numShots      = 16'(shots);
    shotInterval  = 32'(gap);
    timeoutCycles = 32'(tmo);
    channelEnable = m;
    trig          = 1'b1;
    abort         = 1'b0;
    fireComplete  = NCH'($urandom);
    @(posedge clk); #1;
    for (int i = 1; i < sched.size(); i++) begin
      checkOutputs(sched[i]);
      // Config noise and stray trig while busy must be ignored.
      trig          = (i < sched.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      numShots      = 16'($urandom);
      shotInterval  = $urandom;
      timeoutCycles = $urandom_range(1, 3);
      channelEnable = NCH'($urandom);
      abort         = !killTmo && (i == killAt);
      if (sched[i].lastFire)    fireComplete = m | NCH'($urandom);
      else if (sched[i].inFire) fireComplete = NCH'($urandom) & ~lowBit;
      else                      fireComplete = NCH'($urandom);
      @(posedge clk); #1;
    end
    lastCount = sched[sched.size() - 1].cnt;
    stickyErr = sched[sched.size() - 1].terr;
    trig  = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    expT z;
    z = '0;
    #3;
    checkOutputs(z);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    idleCycles(3);

    // Directed: single shot, 3-shot burst with long interval, partial mask, timeout, abort in shot 2.
    runBurst(1, 0, 0, 8'h01, 0, 3, 3);
    idleCycles(2);
    runBurst(3, 20, 0, 8'hFF, 0, 1, 4);
    idleCycles(2);
    runBurst(2, 1, 0, 8'h05, 0, 2, 2);
    idleCycles(2);
    runBurst(1, 0, 50, 8'h08, 0, 60, 60);
    idleCycles(2);
    runBurst(4, 2, 0, 8'hFF, 17, 3, 3);
    idleCycles(2);

    // Random bursts, including zero-shot bursts, mid-burst aborts and short timeouts.
    for (int b = 0; b < 30; b++) begin
      runBurst($urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 5)),
               NCH'($urandom),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0,
               1, 6);
      idleCycles($urandom_range(1, 3));
    end

    // Asynchronous reset while in FIRE: outputs drop with no clock edge.
    numShots      = 16'd5;
    shotInterval  = 32'd3;
    timeoutCycles = 32'd0;
    channelEnable = 8'h0F;
    fireComplete  = '0;
    trig          = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
    repeat (1 + ARM) @(posedge clk);
    #1;
    check("fireBeforeReset", 32'(GOGOGO_EXCLAMATION), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutputs(z);
    @(negedge clk) rst = 1'b1;
    lastCount = '0;
    stickyErr = 1'b0;
    @(posedge clk); #1;
    idleCycles(2);

    // Zero-shot trigger after reset: done next cycle, no strobes.
    runBurst(0, 0, 0, 8'hFF, 0, 1, 1);
    idleCycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
